active_list: RTL and testbench

In-order tracking buffer for the out-of-order MIPS core; the program-order counterpart of the instruction queue. It allocates one entry per dispatched, renamed instruction and records completions from execute. It retires entries in order, returning superseded physical registers to the free list. On a branch mispredict it walks back younger entries over multiple cycles, undoing their rename mappings, and drives the flush / flush-done handshake that gates instruction queue insertion.

---
 rtl/active_list.sv | 252 +++++++++++++++++++++++++
 tb/tb_active_list.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/active_list.sv
// In-order tracking buffer: allocates entries at dispatch, retires them in
// program order, and walks younger entries back one per cycle after a mispredict.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module active_list #(
  parameter int DEPTH    = 32,
  parameter int ID_WIDTH = `ADDR_WIDTH,
  parameter int PREG_W   = 6,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic [ID_WIDTH-1:0] alloc_id,
  input  logic                alloc_uses_rw,
  input  logic [4:0]          alloc_arch_rw,
  input  logic [PREG_W-1:0]   alloc_new_preg,
  input  logic [PREG_W-1:0]   alloc_old_preg,
  output logic                alloc_ready,
  output logic [IDX_W-1:0]    alloc_index,
  input  logic                complete_valid,
  input  logic [IDX_W-1:0]    complete_index,
  input  logic                mispredict_valid,
  input  logic [IDX_W-1:0]    mispredict_index,
  output logic                commit_valid,
  output logic [ID_WIDTH-1:0] commit_id,
  output logic                commit_free_valid,
  output logic [PREG_W-1:0]   commit_free_preg,
  output logic                flush,
  output logic [ID_WIDTH-1:0] flushed_instruction_ID,
  output logic                flush_done,
  output logic                restore_valid,
  output logic [4:0]          restore_arch_rw,
  output logic [PREG_W-1:0]   restore_old_preg,
  output logic [PREG_W-1:0]   restore_new_preg,
  output logic [IDX_W:0]      count,
  output logic                empty,
  output logic                full
);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_WALK = 1'b1} state_e;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  // Distance from the head; smaller means older in program order.
  function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] idx,
                                              input logic [IDX_W-1:0] hd);
    return idx - hd;
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d, br_q, br_d;
  logic [IDX_W:0]      count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d, done_q, done_d;

  logic [ID_WIDTH-1:0] id_q       [DEPTH];
  logic                uses_rw_q  [DEPTH];
  logic [4:0]          arch_rw_q  [DEPTH];
  logic [PREG_W-1:0]   new_preg_q [DEPTH];
  logic [PREG_W-1:0]   old_preg_q [DEPTH];

  logic                commit_valid_q, commit_valid_d;
  logic [ID_WIDTH-1:0] commit_id_q, commit_id_d;
  logic                commit_free_valid_q, commit_free_valid_d;
  logic [PREG_W-1:0]   commit_free_preg_q, commit_free_preg_d;
  logic                flush_q, flush_d, flush_done_q, flush_done_d;
  logic [ID_WIDTH-1:0] flushed_id_q, flushed_id_d;
  logic                restore_valid_q, restore_valid_d;
  logic [4:0]          restore_arch_q, restore_arch_d;
  logic [PREG_W-1:0]   restore_old_q, restore_old_d, restore_new_q, restore_new_d;

  logic                full_s, alloc_fire_s, commit_fire_s, retarget_s, walk_end_s;
  logic [IDX_W-1:0]    tail_m1_s, br_eff_s, br_next_s;

  assign full_s        = (count_q == DEPTH_C);
  assign alloc_ready   = (state_q == ST_NORMAL) && !full_s && !mispredict_valid;
  assign alloc_fire_s  = alloc_valid && alloc_ready;
  assign commit_fire_s = (state_q == ST_NORMAL) && (count_q != '0) &&
                         valid_q[head_q] && done_q[head_q];
  assign tail_m1_s     = tail_q - IDX_W'(1);
  // An older mispredict arriving mid-walk takes effect at the same edge.
  assign retarget_s    = (state_q == ST_WALK) && mispredict_valid &&
                         (age_of(mispredict_index, head_q) < age_of(br_q, head_q));
  assign br_eff_s      = retarget_s ? mispredict_index : br_q;
  assign br_next_s     = br_eff_s + IDX_W'(1);
  assign walk_end_s    = (tail_q == br_next_s);

  // Next-state logic for pointers, slot flags and registered outputs.
  always_comb begin
    state_d             = state_q;
    head_d              = head_q;
    tail_d              = tail_q;
    br_d                = br_q;
    count_d             = count_q;
    valid_d             = valid_q;
    done_d              = done_q;
    flush_d             = flush_q;
    flushed_id_d        = flushed_id_q;
    flush_done_d        = 1'b0;
    commit_valid_d      = 1'b0;
    commit_id_d         = '0;
    commit_free_valid_d = 1'b0;
    commit_free_preg_d  = '0;
    restore_valid_d     = 1'b0;
    restore_arch_d      = '0;
    restore_old_d       = '0;
    restore_new_d       = '0;

    if (complete_valid && valid_q[complete_index]) begin
      done_d[complete_index] = 1'b1;
    end else begin
      done_d[complete_index] = done_q[complete_index];
    end

    case (state_q)
      ST_NORMAL: begin
        if (alloc_fire_s) begin
          valid_d[tail_q] = 1'b1;
          done_d[tail_q]  = 1'b0;
          tail_d          = tail_q + IDX_W'(1);
        end else begin
          tail_d = tail_q;
        end
        if (commit_fire_s) begin
          valid_d[head_q]     = 1'b0;
          head_d              = head_q + IDX_W'(1);
          commit_valid_d      = 1'b1;
          commit_id_d         = id_q[head_q];
          commit_free_valid_d = uses_rw_q[head_q];
          commit_free_preg_d  = old_preg_q[head_q];
        end else begin
          head_d = head_q;
        end
        count_d = count_q + (IDX_W+1)'(alloc_fire_s) - (IDX_W+1)'(commit_fire_s);
        if (mispredict_valid) begin
          done_d[mispredict_index] = 1'b1;
          br_d                     = mispredict_index;
          flushed_id_d             = id_q[mispredict_index];
          flush_d                  = 1'b1;
          state_d                  = ST_WALK;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_WALK: begin
        if (retarget_s) begin
          done_d[mispredict_index] = 1'b1;
          br_d                     = mispredict_index;
          flushed_id_d             = id_q[mispredict_index];
        end else begin
          br_d = br_q;
        end
        if (walk_end_s) begin
          flush_d      = 1'b0;
          flush_done_d = 1'b1;
          state_d      = ST_NORMAL;
        end else begin
          valid_d[tail_m1_s] = 1'b0;
          tail_d             = tail_m1_s;
          count_d            = count_q - (IDX_W+1)'(1);
          restore_valid_d    = uses_rw_q[tail_m1_s];
          restore_arch_d     = arch_rw_q[tail_m1_s];
          restore_old_d      = old_preg_q[tail_m1_s];
          restore_new_d      = new_preg_q[tail_m1_s];
        end
      end
      default: begin
        state_d = ST_NORMAL;
        flush_d = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= ST_NORMAL;
      head_q              <= '0;
      tail_q              <= '0;
      br_q                <= '0;
      count_q             <= '0;
      valid_q             <= '0;
      done_q              <= '0;
      flush_q             <= 1'b0;
      flushed_id_q        <= '0;
      flush_done_q        <= 1'b0;
      commit_valid_q      <= 1'b0;
      commit_id_q         <= '0;
      commit_free_valid_q <= 1'b0;
      commit_free_preg_q  <= '0;
      restore_valid_q     <= 1'b0;
      restore_arch_q      <= '0;
      restore_old_q       <= '0;
      restore_new_q       <= '0;
    end else begin
      state_q             <= state_d;
      head_q              <= head_d;
      tail_q              <= tail_d;
      br_q                <= br_d;
      count_q             <= count_d;
      valid_q             <= valid_d;
      done_q              <= done_d;
      flush_q             <= flush_d;
      flushed_id_q        <= flushed_id_d;
      flush_done_q        <= flush_done_d;
      commit_valid_q      <= commit_valid_d;
      commit_id_q         <= commit_id_d;
      commit_free_valid_q <= commit_free_valid_d;
      commit_free_preg_q  <= commit_free_preg_d;
      restore_valid_q     <= restore_valid_d;
      restore_arch_q      <= restore_arch_d;
      restore_old_q       <= restore_old_d;
      restore_new_q       <= restore_new_d;
    end
  end

  // Slot payload; only read while the slot's valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire_s) begin
      id_q[tail_q]       <= alloc_id;
      uses_rw_q[tail_q]  <= alloc_uses_rw;
      arch_rw_q[tail_q]  <= alloc_arch_rw;
      new_preg_q[tail_q] <= alloc_new_preg;
      old_preg_q[tail_q] <= alloc_old_preg;
    end else begin
      id_q[tail_q]       <= id_q[tail_q];
      uses_rw_q[tail_q]  <= uses_rw_q[tail_q];
      arch_rw_q[tail_q]  <= arch_rw_q[tail_q];
      new_preg_q[tail_q] <= new_preg_q[tail_q];
      old_preg_q[tail_q] <= old_preg_q[tail_q];
    end
  end

  assign alloc_index            = tail_q;
  assign commit_valid           = commit_valid_q;
  assign commit_id              = commit_id_q;
  assign commit_free_valid      = commit_free_valid_q;
  assign commit_free_preg       = commit_free_preg_q;
  assign flush                  = flush_q;
  assign flushed_instruction_ID = flushed_id_q;
  assign flush_done             = flush_done_q;
  assign restore_valid          = restore_valid_q;
  assign restore_arch_rw        = restore_arch_q;
  assign restore_old_preg       = restore_old_q;
  assign restore_new_preg       = restore_new_q;
  assign count                  = count_q;
  assign empty                  = (count_q == '0);
  assign full                   = full_s;

endmodule

// File: tb/tb_active_list.sv
// Directed bench for active_list: fill/overflow, in-order commit, walk-back,
// retarget, pointer wrap and reset during a walk.
module tb_active_list;

  localparam int DEPTH = 32;
  localparam int ID_W  = 32;
  localparam int PW    = 6;
  localparam int IW    = 5;

  logic            clk, rst_n;
  logic            alloc_valid, alloc_uses_rw, alloc_ready;
  logic [ID_W-1:0] alloc_id;
  logic [4:0]      alloc_arch_rw;
  logic [PW-1:0]   alloc_new_preg, alloc_old_preg;
  logic [IW-1:0]   alloc_index;
  logic            complete_valid, mispredict_valid;
  logic [IW-1:0]   complete_index, mispredict_index;
  logic            commit_valid, commit_free_valid;
  logic [ID_W-1:0] commit_id, flushed_instruction_ID;
  logic [PW-1:0]   commit_free_preg;
  logic            flush, flush_done, restore_valid;
  logic [4:0]      restore_arch_rw;
  logic [PW-1:0]   restore_old_preg, restore_new_preg;
  logic [IW:0]     count;
  logic            empty, full;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  active_list #(.DEPTH(DEPTH), .ID_WIDTH(ID_W), .PREG_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_uses_rw(alloc_uses_rw),
    .alloc_arch_rw(alloc_arch_rw), .alloc_new_preg(alloc_new_preg),
    .alloc_old_preg(alloc_old_preg), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .complete_valid(complete_valid), .complete_index(complete_index),
    .mispredict_valid(mispredict_valid), .mispredict_index(mispredict_index),
    .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_free_valid(commit_free_valid), .commit_free_preg(commit_free_preg),
    .flush(flush), .flushed_instruction_ID(flushed_instruction_ID), .flush_done(flush_done),
    .restore_valid(restore_valid), .restore_arch_rw(restore_arch_rw),
    .restore_old_preg(restore_old_preg), .restore_new_preg(restore_new_preg),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid      = 1'b0;
    complete_valid   = 1'b0;
    mispredict_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic do_alloc(input logic [ID_W-1:0] id, input logic rw, input logic [4:0] arch,
                          input logic [PW-1:0] np, input logic [PW-1:0] op);
    alloc_valid    = 1'b1;
    alloc_id       = id;
    alloc_uses_rw  = rw;
    alloc_arch_rw  = arch;
    alloc_new_preg = np;
    alloc_old_preg = op;
    tick();
    alloc_valid    = 1'b0;
  endtask

  task automatic do_complete(input logic [IW-1:0] idx);
    complete_valid = 1'b1;
    complete_index = idx;
    tick();
    complete_valid = 1'b0;
  endtask

  task automatic do_mispredict(input logic [IW-1:0] idx);
    mispredict_valid = 1'b1;
    mispredict_index = idx;
    tick();
    mispredict_valid = 1'b0;
  endtask

  task automatic wait_flush_done(input string tag);
    int n = 0;
    while (flush_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, flush_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    idle();
    alloc_id = '0; alloc_uses_rw = 1'b0; alloc_arch_rw = '0;
    alloc_new_preg = '0; alloc_old_preg = '0;
    complete_index = '0; mispredict_index = '0;
    #12;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_flush", flush, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_restore", restore_valid, 0);
    chk("rst_flush_id", flushed_instruction_ID, 0);
    chk("rst_index", alloc_index, 0);
    rst_n = 1'b1;

    // Fill all 32 slots, then offer a 33rd.
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_index", alloc_index, i);
      chk("fill_ready", alloc_ready, 1);
      do_alloc(100 + i, 1'b1, 5'(i), 6'(i + 32), 6'(i));
    end
    chk("full_flag", full, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 32);
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    chk("over_count", count, 32);
    chk("over_index", alloc_index, 0);

    // Out-of-order completion, in-order retirement.
    do_reset();
    chk("rst2_empty", empty, 1);
    do_alloc(20, 1'b1, 5'd1, 6'd50, 6'd40);
    do_alloc(21, 1'b1, 5'd2, 6'd51, 6'd41);
    do_alloc(22, 1'b1, 5'd3, 6'd52, 6'd42);
    do_complete(5'd2);
    chk("c2_no_commit", commit_valid, 0);
    do_complete(5'd1);
    chk("c1_no_commit", commit_valid, 0);
    do_complete(5'd0);
    chk("c0_latency", commit_valid, 0);
    tick();
    chk("cm0_valid", commit_valid, 1);
    chk("cm0_id", commit_id, 20);
    chk("cm0_free_valid", commit_free_valid, 1);
    chk("cm0_free_preg", commit_free_preg, 40);
    tick();
    chk("cm1_valid", commit_valid, 1);
    chk("cm1_id", commit_id, 21);
    chk("cm1_free_preg", commit_free_preg, 41);
    tick();
    chk("cm2_valid", commit_valid, 1);
    chk("cm2_id", commit_id, 22);
    chk("cm2_free_preg", commit_free_preg, 42);
    tick();
    chk("cm_end_valid", commit_valid, 0);
    chk("cm_end_empty", empty, 1);

    // Mispredict slot 2 with three younger entries.
    do_reset();
    for (int k = 0; k < 6; k++) do_alloc(10 + k, 1'b1, 5'(k + 1), 6'(k + 20), 6'(k + 30));
    mispredict_valid = 1'b1;
    mispredict_index = 5'd2;
    #1;
    chk("mp_refuse", alloc_ready, 0);
    tick();
    mispredict_valid = 1'b0;
    chk("mp_flush", flush, 1);
    chk("mp_flush_id", flushed_instruction_ID, 12);
    chk("mp_no_restore", restore_valid, 0);
    chk("mp_ready", alloc_ready, 0);
    for (int k = 5; k >= 3; k--) begin
      tick();
      chk("walk_restore_valid", restore_valid, 1);
      chk("walk_restore_arch", restore_arch_rw, k + 1);
      chk("walk_restore_old", restore_old_preg, k + 30);
      chk("walk_restore_new", restore_new_preg, k + 20);
      chk("walk_flush", flush, 1);
    end
    tick();
    chk("walk_end_flush", flush, 0);
    chk("walk_end_done", flush_done, 1);
    chk("walk_end_restore", restore_valid, 0);
    chk("walk_end_tail", alloc_index, 3);
    chk("walk_end_count", count, 3);
    chk("walk_end_ready", alloc_ready, 1);
    tick();
    chk("done_pulse", flush_done, 0);

    // Retarget to an older branch mid-walk; a younger one is ignored.
    for (int k = 3; k < 6; k++) do_alloc(20 + k, 1'b1, 5'(k + 1), 6'(k + 20), 6'(k + 30));
    do_mispredict(5'd4);
    chk("rt_first_id", flushed_instruction_ID, 24);
    do_mispredict(5'd1);
    chk("rt_retarget_id", flushed_instruction_ID, 11);
    chk("rt_pop5_arch", restore_arch_rw, 6);
    do_mispredict(5'd5);
    chk("rt_ignore_id", flushed_instruction_ID, 11);
    chk("rt_pop4_arch", restore_arch_rw, 5);
    wait_flush_done("rt_flush_done");
    chk("rt_tail", alloc_index, 2);
    chk("rt_count", count, 2);
    chk("rt_final_id", flushed_instruction_ID, 11);
    tick();

    // Move head to 30 through streaming alloc/complete/commit.
    do_reset();
    for (int i = 0; i <= 30; i++) begin
      alloc_valid    = (i < 30);
      alloc_id       = 300 + i;
      alloc_uses_rw  = 1'b0;
      alloc_arch_rw  = '0;
      alloc_new_preg = '0;
      alloc_old_preg = '0;
      complete_valid = (i > 0);
      complete_index = 5'(i - 1);
      tick();
      if (i == 10) begin
        chk("stream_commit", commit_valid, 1);
        chk("stream_id", commit_id, 308);
        chk("stream_free_valid", commit_free_valid, 0);
        chk("stream_count", count, 2);
      end
    end
    idle();
    tick(); tick(); tick();
    chk("stream_empty", empty, 1);
    chk("stream_tail", alloc_index, 30);
    for (int j = 0; j < 5; j++) begin
      chk("wrap_index", alloc_index, (30 + j) % 32);
      do_alloc(200 + j, 1'b1, 5'(j + 1), 6'(j + 10), 6'(j + 40));
    end
    chk("wrap_tail", alloc_index, 3);
    chk("wrap_count", count, 5);
    do_mispredict(5'd31);
    chk("wrap_flush_id", flushed_instruction_ID, 201);
    for (int j = 4; j >= 2; j--) begin
      tick();
      chk("wrap_restore_valid", restore_valid, 1);
      chk("wrap_restore_arch", restore_arch_rw, j + 1);
      chk("wrap_restore_new", restore_new_preg, j + 10);
      chk("wrap_restore_old", restore_old_preg, j + 40);
    end
    tick();
    chk("wrap_done", flush_done, 1);
    chk("wrap_final_tail", alloc_index, 0);
    chk("wrap_final_count", count, 2);
    tick();

    // Asynchronous reset in the middle of a walk.
    for (int j = 0; j < 3; j++) do_alloc(400 + j, 1'b1, 5'(j + 7), 6'(j + 1), 6'(j + 2));
    do_mispredict(5'd30);
    tick();
    chk("mid_restore_valid", restore_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_restore", restore_valid, 0);
    chk("mid_rst_ready", alloc_ready, 1);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_flush_id", flushed_instruction_ID, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_flush", flush, 0);
    chk("post_rst_done", flush_done, 0);
    chk("post_rst_tail", alloc_index, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
